// File: rtl/autoplay_driver.sv
// Script-driven autoplayer: replays a 16-entry move script into the room logic,
// one move per GAP_CYCLES+1 clocks, stopping on end-of-script, wrap or game outcome.
// Optional AUTOPLAY_GAME_RESET_EN adds a one-cycle game_reset pulse before playback.
module autoplay_driver #(
  parameter int GAP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] outcome,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [2:0] wr_data,
  output logic [2:0] direction,
  output logic       game_reset,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic [3:0] step
);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef AUTOPLAY_GAME_RESET_EN
    S_PULSE,
`endif
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);

  state_t          state_q, state_d;
  logic [2:0]      direction_q, direction_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      result_q, result_d;
  logic [3:0]      step_q, step_d;
  logic [7:0]      gap_q, gap_d;
  logic            wrap_q, wrap_d;
  logic [15:0][2:0] script_q, script_d;
  logic [2:0]      cur;
  logic [1:0]      term;
`ifdef AUTOPLAY_GAME_RESET_EN
  logic            game_reset_q, game_reset_d;
`endif

  // An outcome of 11 is reported as a plain loss.
  assign term = (outcome == 2'b11) ? 2'b10 : outcome;
  assign cur  = script_q[step_q];

  always_comb begin
    script_d = script_q;
    if (wr_en && !busy_q) script_d[wr_addr] = wr_data;
  end

  always_comb begin
    state_d     = state_q;
    direction_d = 3'd7;
    busy_d      = busy_q;
    done_d      = done_q;
    result_d    = result_q;
    step_d      = step_q;
    gap_d       = gap_q;
    wrap_d      = wrap_q;
`ifdef AUTOPLAY_GAME_RESET_EN
    game_reset_d = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d   = 1'b0;
          result_d = 2'b00;
          step_d   = 4'd0;
          busy_d   = 1'b1;
          gap_d    = 8'd0;
          wrap_d   = 1'b0;
`ifdef AUTOPLAY_GAME_RESET_EN
          game_reset_d = 1'b1;
          state_d      = S_PULSE;
`else
          state_d  = S_ISSUE;
`endif
        end
      end
`ifdef AUTOPLAY_GAME_RESET_EN
      S_PULSE: state_d = S_ISSUE;
`endif
      S_ISSUE: begin
        if (outcome != 2'b00) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = term;
        end else if (wrap_q || cur[2]) begin
          // wrap_q: all 16 entries already issued, entry 0 must not replay
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = 2'b00;
        end else begin
          direction_d = {1'b0, cur[1:0]};
          step_d      = step_q + 4'd1;
          wrap_d      = (step_q == 4'd15);
          gap_d       = GAP_RELOAD;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (outcome != 2'b00) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = term;
        end else if (gap_q == 8'd0) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      direction_q <= 3'd7;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 2'b00;
      step_q      <= 4'd0;
      gap_q       <= 8'd0;
      wrap_q      <= 1'b0;
      script_q    <= {16{3'd7}};
`ifdef AUTOPLAY_GAME_RESET_EN
      game_reset_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      direction_q <= direction_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      step_q      <= step_d;
      gap_q       <= gap_d;
      wrap_q      <= wrap_d;
      script_q    <= script_d;
`ifdef AUTOPLAY_GAME_RESET_EN
      game_reset_q <= game_reset_d;
`endif
    end
  end

  assign direction = direction_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign step      = step_q;
`ifdef AUTOPLAY_GAME_RESET_EN
  assign game_reset = game_reset_q;
`else
  assign game_reset = 1'b0;
`endif

endmodule

// File: tb/tb_autoplay_driver.sv
// Directed self-checking bench for autoplay_driver (GAP_CYCLES=4).
module tb_autoplay_driver;

`ifdef AUTOPLAY_GAME_RESET_EN
  localparam int   OFF    = 1;
  localparam logic GR_EXP = 1'b1;
`else
  localparam int   OFF    = 0;
  localparam logic GR_EXP = 1'b0;
`endif

  logic       clock, reset, start, wr_en;
  logic [1:0] outcome;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
  logic [2:0] direction;
  logic       game_reset, busy, done;
  logic [1:0] result;
  logic [3:0] step;

  int checks = 0;
  int errors = 0;

  autoplay_driver #(.GAP_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .start(start), .outcome(outcome),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .direction(direction), .game_reset(game_reset), .busy(busy),
    .done(done), .result(result), .step(step)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || step !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: busy=%b step=%0d done=%b, want busy=1 step=0 done=0", busy, step, done);
    end
    checks++;
    if (game_reset !== GR_EXP) begin
      errors++;
      $display("FAIL start_game_reset: got %b want %b", game_reset, GR_EXP);
    end
  endtask

  task automatic write_basic_script;
    write_entry(4'd0, 3'd1);
    write_entry(4'd1, 3'd2);
    write_entry(4'd2, 3'd0);
    write_entry(4'd3, 3'd3);
    write_entry(4'd4, 3'd7);
  endtask

  function automatic logic [2:0] basic_dir(input int k);
    case (k - OFF)
      1:  return 3'd1;
      6:  return 3'd2;
      11: return 3'd0;
      16: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  task automatic check_finish(input string name, input logic [1:0] res, input logic [3:0] st);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== res || step !== st || direction !== 3'd7) begin
      errors++;
      $display("FAIL %s: done=%b busy=%b result=%b step=%0d dir=%0d, want done=1 busy=0 result=%b step=%0d dir=7",
               name, done, busy, result, step, direction, res, st);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (direction !== 3'd7 || game_reset !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        result !== 2'b00 || step !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: dir=%0d grst=%b busy=%b done=%b result=%b step=%0d",
               direction, game_reset, busy, done, result, step);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || direction !== 3'd7) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b dir=%0d", busy, direction);
    end
  endtask

  task automatic test_basic;
    write_basic_script();
    do_start();
    for (int k = 1; k <= 22; k++) begin
      tick();
      checks++;
      if (direction !== basic_dir(k)) begin
        errors++;
        $display("FAIL basic_dir[%0d]: got %0d want %0d", k, direction, basic_dir(k));
      end
      checks++;
      if (game_reset !== 1'b0) begin
        errors++;
        $display("FAIL basic_grst[%0d]: got %b want 0", k, game_reset);
      end
      if (k == 20 + OFF) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_pre_done: done=%b busy=%b want 0/1", done, busy);
        end
      end
    end
    check_finish("basic_finish", 2'b00, 4'd4);
  endtask

  task automatic test_outcome;
    do_start();
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (direction !== ((k == 1 + OFF) ? 3'd1 : (k == 6 + OFF) ? 3'd2 : 3'd7)) begin
        errors++;
        $display("FAIL outcome_dir[%0d]: got %0d", k, direction);
      end
      if (k == 6 + OFF) outcome = 2'b01;
      if (k == 7 + OFF) check_finish("outcome_won", 2'b01, 4'd2);
    end
    outcome = 2'b00;
    check_finish("outcome_won_hold", 2'b01, 4'd2);

    do_start();
    repeat (OFF) tick();
    tick();
    checks++;
    if (direction !== 3'd1) begin
      errors++;
      $display("FAIL outcome11_first: got %0d want 1", direction);
    end
    outcome = 2'b11;
    tick();
    outcome = 2'b00;
    check_finish("outcome11_lost", 2'b10, 4'd1);
  endtask

  task automatic test_wrap;
    int moves;
    moves = 0;
    for (int i = 0; i < 16; i++) write_entry(4'(i), 3'd2);
    do_start();
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (direction !== 3'd7) begin
        moves++;
        checks++;
        if (direction !== 3'd2) begin
          errors++;
          $display("FAIL wrap_dir[%0d]: got %0d want 2", k, direction);
        end
      end
    end
    checks++;
    if (moves != 16) begin
      errors++;
      $display("FAIL wrap_moves: got %0d want 16", moves);
    end
    check_finish("wrap_finish", 2'b00, 4'd0);
  endtask

  task automatic test_busy_write;
    write_basic_script();
    do_start();
    for (int k = 1; k <= 22; k++) begin
      if (k == 3) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 3'd0;
      end
      tick();
      wr_en = 1'b0;
      checks++;
      if (direction !== basic_dir(k)) begin
        errors++;
        $display("FAIL busy_write_dir[%0d]: got %0d want %0d", k, direction, basic_dir(k));
      end
    end
    check_finish("busy_write_finish", 2'b00, 4'd4);
  endtask

  task automatic test_reset_mid;
    do_start();
    repeat (2 + OFF) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (direction !== 3'd7 || busy !== 1'b0 || step !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: dir=%0d busy=%b step=%0d done=%b", direction, busy, step, done);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (direction !== 3'd7 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet[%0d]: dir=%0d busy=%b", k, direction, busy);
      end
    end
    do_start();
    repeat (OFF) tick();
    tick();
    check_finish("reset_script_cleared", 2'b00, 4'd0);
  endtask

  task automatic test_start_write;
    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 3'd3;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (direction !== ((k == 1 + OFF) ? 3'd3 : 3'd7)) begin
        errors++;
        $display("FAIL start_write_dir[%0d]: got %0d", k, direction);
      end
    end
    check_finish("start_write_finish", 2'b00, 4'd1);
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; start = 1'b0; outcome = 2'b00;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 3'd0;
    test_reset();
    test_basic();
    test_outcome();
    test_wrap();
    test_busy_write();
    test_reset_mid();
    test_start_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
